servo_btn_cond: RTL and testbench
=================================

SERVO_BTN_COND -- requirements
Module: servo_btn_cond

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` and `rst`, with all state sampled on the rising edge of `clk`.
REQ-002 Parameter `DEBOUNCE_TICK`, default 500000, SHALL be the number of cycles a synchronized input must stay stable before it is accepted (10 ms at 50 MHz); its legal range SHALL be 1 to 2^24-1.
REQ-003 Parameter `ACTIVE_LOW`, default 0, SHALL invert both raw button inputs when set to 1, so that a pressed button reads as 1 internally.
REQ-004 Port `clk`, input, 1 bit: system clock, 50 MHz.
REQ-005 Port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-006 Port `l_btn`, input, 1 bit: raw, asynchronous, bouncing left pushbutton.
REQ-007 Port `r_btn`, input, 1 bit: raw, asynchronous, bouncing right pushbutton.
REQ-008 Port `l_ctrl`, output, 1 bit: cleaned left-move level that drives the servo stage's left control input.
REQ-009 Port `r_ctrl`, output, 1 bit: cleaned right-move level that drives the servo stage's right control input.
REQ-010 Port `l_press`, output, 1 bit: single-cycle pulse on each accepted left press.
REQ-011 Port `r_press`, output, 1 bit: single-cycle pulse on each accepted right press.
REQ-012 Port `conflict`, output, 1 bit: high while both buttons are held.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer (s1, then s2), after the `ACTIVE_LOW` inversion, before any other logic uses it.
REQ-014 Each button SHALL have its own debounce counter (24 bit, unsigned) and its own debounced bit db.
- The counter SHALL increment every cycle while s2 != db.
- The counter SHALL clear to 0 in any cycle where s2 == db.
REQ-015 When s2 != db and the counter equals `DEBOUNCE_TICK`-1, db SHALL take the value of s2 and the counter SHALL clear on that edge.
- A glitch shorter than `DEBOUNCE_TICK` cycles therefore SHALL never change db.
REQ-016 The control FSM SHALL have exactly four registered states, IDLE, LEFT, RIGHT and CONFLICT, with transitions evaluated from (dbL, dbR):
- IDLE: (1,0) -> LEFT; (0,1) -> RIGHT; (1,1) -> CONFLICT; (0,0) -> stay.
- LEFT: dbL=0 -> IDLE; dbR=1 -> CONFLICT (when both hold, CONFLICT wins); otherwise stay.
- RIGHT: dbR=0 -> IDLE; dbL=1 -> CONFLICT (when both hold, CONFLICT wins); otherwise stay.
- CONFLICT: (0,0) -> IDLE; any other value -> stay. The FSM SHALL never go directly from CONFLICT to LEFT or RIGHT.
REQ-017 Outputs SHALL be decoded from the state register only:
- `l_ctrl` = (state==LEFT).
- `r_ctrl` = (state==RIGHT).
- `conflict` = (state==CONFLICT).
- `l_ctrl` and `r_ctrl` SHALL never be high at the same time.
REQ-018 `l_press` SHALL be a registered output that is high for exactly the first cycle `l_ctrl` is high (IDLE->LEFT); `r_press` SHALL behave the same way for IDLE->RIGHT.
REQ-019 Press-to-output latency SHALL be `DEBOUNCE_TICK`+3 rising edges, counting the first edge that samples the raw press as edge 1. Release-to-deassert latency SHALL be the same.
REQ-020 A press that starts while the other button is already held SHALL NOT raise `l_ctrl`, `r_ctrl`, `l_press` or `r_press`.
REQ-021 Holding one button for any length of time SHALL keep its control output high continuously, with no auto-repeat pulses on `l_press` or `r_press`.

Reset
REQ-022 While `rst` is high at a clock edge, the following SHALL take the values listed on that edge:
- s1, s2 and db for both buttons: 0.
- Both debounce counters: 0.
- FSM state: IDLE.
- `l_ctrl`, `r_ctrl`, `l_press`, `r_press`, `conflict`: 0.
REQ-023 A reset asserted in the middle of a debounce SHALL discard all counting progress. A button held through reset SHALL be re-accepted only after a full `DEBOUNCE_TICK`+3 edges have elapsed after `rst` falls.

Verification (`DEBOUNCE_TICK`=4, `ACTIVE_LOW`=0)
REQ-024 Left clean press: `l_btn`=1 held from edge 1 -> `l_ctrl`=1 and `l_press`=1 after edge 7; `l_press`=0 after edge 8; `l_ctrl` stays 1 until 7 edges after release.
REQ-025 Glitch rejection: `r_btn` pulses 1 for 3 cycles and then returns to 0 -> `r_ctrl`, `r_press` and `conflict` stay 0 throughout.
REQ-026 Simultaneous press: `l_btn` and `r_btn` both go to 1 on the same edge -> `conflict`=1 after edge 7, and `l_ctrl`, `r_ctrl`, `l_press`, `r_press` are never 1.
REQ-027 Late second press: hold left until `l_ctrl`=1, then press right -> `l_ctrl`=0 and `conflict`=1 seven edges after the right press. Then release right only -> the FSM stays in CONFLICT and `l_ctrl` stays 0.
REQ-028 Reset mid-operation: assert `rst` for 1 cycle while in LEFT with `l_btn` still held -> all outputs read 0 on the next cycle, and `l_ctrl`/`l_press` reassert 7 edges after `rst` falls.
REQ-029 Polarity: with `ACTIVE_LOW`=1 and both raw inputs idling at 1, drive `l_btn`=0 -> identical timing to REQ-024.

Source files
------------

// File: rtl/servo_btn_cond.sv
// Conditions two raw pushbuttons (synchronize, debounce) and arbitrates them
// into mutually exclusive left/right servo control levels plus press pulses.
module servo_btn_cond #(
  parameter int DEBOUNCE_TICK = 500000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic l_btn,
  input  logic r_btn,
  output logic l_ctrl,
  output logic r_ctrl,
  output logic l_press,
  output logic r_press,
  output logic conflict
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEFT     = 2'd1,
    RIGHT    = 2'd2,
    CONFLICT = 2'd3
  } state_t;

  localparam logic [23:0] TICK_M1 = 24'(DEBOUNCE_TICK - 1);
  localparam logic [1:0]  INV     = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  // Index 0 is the left button, index 1 the right button.
  logic [1:0]  raw;
  logic [1:0]  s1;
  logic [1:0]  s2;
  logic [1:0]  db;
  logic [23:0] cnt [2];

  state_t state;
  state_t nxt;

  assign raw = {r_btn, l_btn} ^ INV;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
      db <= 2'b00;
      for (int i = 0; i < 2; i++) cnt[i] <= 24'd0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= 24'd0;
        end else if (cnt[i] == TICK_M1) begin
          db[i]  <= s2[i];
          cnt[i] <= 24'd0;
        end else begin
          cnt[i] <= cnt[i] + 24'd1;
        end
      end
    end
  end

  // CONFLICT only drains through IDLE, so a late press never hands control over.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        case (db)
          2'b01:   nxt = LEFT;
          2'b10:   nxt = RIGHT;
          2'b11:   nxt = CONFLICT;
          default: nxt = IDLE;
        endcase
      end
      LEFT: begin
        if (db[1])       nxt = CONFLICT;
        else if (!db[0]) nxt = IDLE;
      end
      RIGHT: begin
        if (db[0])       nxt = CONFLICT;
        else if (!db[1]) nxt = IDLE;
      end
      CONFLICT: begin
        if (db == 2'b00) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered copies of the state decode, so they track state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      l_ctrl   <= 1'b0;
      r_ctrl   <= 1'b0;
      conflict <= 1'b0;
      l_press  <= 1'b0;
      r_press  <= 1'b0;
    end else begin
      state    <= nxt;
      l_ctrl   <= (nxt == LEFT);
      r_ctrl   <= (nxt == RIGHT);
      conflict <= (nxt == CONFLICT);
      l_press  <= (state == IDLE) && (nxt == LEFT);
      r_press  <= (state == IDLE) && (nxt == RIGHT);
    end
  end

endmodule

// File: tb/tb_servo_btn_cond.sv
// Directed bench for servo_btn_cond with DEBOUNCE_TICK=4: one active-high
// instance for the main scenarios and one active-low instance for polarity.
module tb_servo_btn_cond;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic l_btn = 1'b0, r_btn = 1'b0;
  logic l_ctrl, r_ctrl, l_press, r_press, conflict;

  logic l_btn_n = 1'b1, r_btn_n = 1'b1;
  logic l_ctrl_n, r_ctrl_n, l_press_n, r_press_n, conflict_n;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  servo_btn_cond #(.DEBOUNCE_TICK(4), .ACTIVE_LOW(0)) u_hi (
    .clk(clk), .rst(rst), .l_btn(l_btn), .r_btn(r_btn),
    .l_ctrl(l_ctrl), .r_ctrl(r_ctrl), .l_press(l_press), .r_press(r_press),
    .conflict(conflict)
  );

  servo_btn_cond #(.DEBOUNCE_TICK(4), .ACTIVE_LOW(1)) u_lo (
    .clk(clk), .rst(rst), .l_btn(l_btn_n), .r_btn(r_btn_n),
    .l_ctrl(l_ctrl_n), .r_ctrl(r_ctrl_n), .l_press(l_press_n), .r_press(r_press_n),
    .conflict(conflict_n)
  );

  // Advance n rising edges, then settle 1 time unit so outputs are sampled off-edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".l_ctrl"},   l_ctrl,   1'b0);
    chk({tag, ".r_ctrl"},   r_ctrl,   1'b0);
    chk({tag, ".l_press"},  l_press,  1'b0);
    chk({tag, ".r_press"},  r_press,  1'b0);
    chk({tag, ".conflict"}, conflict, 1'b0);
  endtask

  initial begin
    // Reset state
    tick(2);
    chk_all_zero("reset");
    chk("reset.lo.l_ctrl", l_ctrl_n, 1'b0);
    rst = 1'b0;
    tick(3);
    chk_all_zero("idle");
    chk("idle.lo.l_ctrl", l_ctrl_n, 1'b0);

    // Left clean press: edge 1 samples the press, output rises after edge 7
    l_btn = 1'b1;
    tick(6);
    chk("left.e6.l_ctrl", l_ctrl, 1'b0);
    chk("left.e6.l_press", l_press, 1'b0);
    tick(1);
    chk("left.e7.l_ctrl", l_ctrl, 1'b1);
    chk("left.e7.l_press", l_press, 1'b1);
    tick(1);
    chk("left.e8.l_press", l_press, 1'b0);
    chk("left.e8.l_ctrl", l_ctrl, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("left.hold.l_ctrl", l_ctrl, 1'b1);
      chk("left.hold.l_press", l_press, 1'b0);
      chk("left.hold.r_ctrl", r_ctrl, 1'b0);
    end
    l_btn = 1'b0;
    tick(6);
    chk("left.rel6.l_ctrl", l_ctrl, 1'b1);
    tick(1);
    chk("left.rel7.l_ctrl", l_ctrl, 1'b0);
    tick(5);

    // Glitch of 3 cycles on right is rejected
    r_btn = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (i == 2) r_btn = 1'b0;
      chk("glitch.r_ctrl", r_ctrl, 1'b0);
      chk("glitch.r_press", r_press, 1'b0);
      chk("glitch.conflict", conflict, 1'b0);
    end

    // Press held exactly 4 cycles is accepted
    r_btn = 1'b1;
    tick(4);
    r_btn = 1'b0;
    tick(2);
    chk("min.e6.r_ctrl", r_ctrl, 1'b0);
    tick(1);
    chk("min.e7.r_ctrl", r_ctrl, 1'b1);
    chk("min.e7.r_press", r_press, 1'b1);
    tick(3);
    chk("min.e10.r_ctrl", r_ctrl, 1'b1);
    tick(1);
    chk("min.e11.r_ctrl", r_ctrl, 1'b0);
    tick(5);

    // Simultaneous press goes straight to conflict
    l_btn = 1'b1;
    r_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      chk("simul.conflict", conflict, (i >= 7));
      chk("simul.l_ctrl", l_ctrl, 1'b0);
      chk("simul.r_ctrl", r_ctrl, 1'b0);
      chk("simul.l_press", l_press, 1'b0);
      chk("simul.r_press", r_press, 1'b0);
    end
    l_btn = 1'b0;
    r_btn = 1'b0;
    tick(6);
    chk("simul.rel6.conflict", conflict, 1'b1);
    tick(1);
    chk("simul.rel7.conflict", conflict, 1'b0);
    tick(5);

    // Late right press while left is active
    l_btn = 1'b1;
    tick(7);
    chk("late.l_ctrl", l_ctrl, 1'b1);
    tick(3);
    r_btn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      chk("late.l_ctrl", l_ctrl, (i < 7));
      chk("late.conflict", conflict, (i >= 7));
      chk("late.r_ctrl", r_ctrl, 1'b0);
      chk("late.r_press", r_press, 1'b0);
    end
    r_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("late.rrel.conflict", conflict, 1'b1);
      chk("late.rrel.l_ctrl", l_ctrl, 1'b0);
      chk("late.rrel.l_press", l_press, 1'b0);
    end
    l_btn = 1'b0;
    tick(7);
    chk("late.lrel.conflict", conflict, 1'b0);
    chk("late.lrel.l_ctrl", l_ctrl, 1'b0);
    tick(5);

    // Reset mid-operation with left still held
    l_btn = 1'b1;
    tick(10);
    chk("rstmid.pre.l_ctrl", l_ctrl, 1'b1);
    rst = 1'b1;
    tick(1);
    chk_all_zero("rstmid");
    rst = 1'b0;
    tick(6);
    chk("rstmid.e6.l_ctrl", l_ctrl, 1'b0);
    chk("rstmid.e6.l_press", l_press, 1'b0);
    tick(1);
    chk("rstmid.e7.l_ctrl", l_ctrl, 1'b1);
    chk("rstmid.e7.l_press", l_press, 1'b1);
    l_btn = 1'b0;
    tick(10);
    chk_all_zero("rstmid.end");

    // Active-low polarity: same timing as the clean left press
    l_btn_n = 1'b0;
    tick(6);
    chk("lo.e6.l_ctrl", l_ctrl_n, 1'b0);
    tick(1);
    chk("lo.e7.l_ctrl", l_ctrl_n, 1'b1);
    chk("lo.e7.l_press", l_press_n, 1'b1);
    chk("lo.e7.r_ctrl", r_ctrl_n, 1'b0);
    tick(1);
    chk("lo.e8.l_press", l_press_n, 1'b0);
    chk("lo.e8.l_ctrl", l_ctrl_n, 1'b1);
    l_btn_n = 1'b1;
    tick(6);
    chk("lo.rel6.l_ctrl", l_ctrl_n, 1'b1);
    tick(1);
    chk("lo.rel7.l_ctrl", l_ctrl_n, 1'b0);
    chk("lo.rel7.conflict", conflict_n, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
